// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_arbiter
// Description : Round-robin arbiter sharing one SPI byte engine between
//               NUM_REQ requesters, one byte frame per grant.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]      req_mode,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        err,
    output logic                      busy,
    output logic [1:0]                state,
    output logic [DATA_W-1:0]         eng_data_wr,
    output logic                      eng_polarity,
    output logic                      eng_phase,
    output logic                      eng_start,
    input  logic                      eng_busy,
    input  logic                      eng_done
);

    localparam int c_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_TCNT_W = $clog2(TIMEOUT);
    localparam int c_GCNT_W = 8;

    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT - 1);
    localparam logic [c_GCNT_W-1:0] c_GCNT_LAST = c_GCNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_GAP  = 2'd3;

    logic [1:0]          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  r_err;
    logic                r_busy;
    logic [DATA_W-1:0]   r_eng_data;
    logic                r_eng_pol;
    logic                r_eng_pha;
    logic                r_eng_start;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [c_GCNT_W-1:0] r_gcnt;
    logic [c_IDX_W-1:0]  r_rr;
    logic [c_IDX_W-1:0]  r_owner;

    logic                w_found;
    logic [c_IDX_W-1:0]  w_winner;
    logic [c_IDX_W-1:0]  w_idx;

    // Scan offsets from farthest to nearest so the nearest requester after
    // the last owner is the final (winning) assignment.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr;
        w_idx    = r_rr;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_idx = c_IDX_W'((int'(r_rr) + off) % NUM_REQ);
            if (req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_grant     <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_busy      <= 1'b0;
            r_eng_data  <= '0;
            r_eng_pol   <= 1'b0;
            r_eng_pha   <= 1'b0;
            r_eng_start <= 1'b0;
            r_tcnt      <= '0;
            r_gcnt      <= '0;
            r_rr        <= c_IDX_W'(NUM_REQ - 1);
            r_owner     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found && !eng_busy) begin
                        r_grant                  <= NUM_REQ'(1) << w_winner;
                        r_owner                  <= w_winner;
                        r_eng_data               <= req_data[int'(w_winner)*DATA_W +: DATA_W];
                        {r_eng_pol, r_eng_pha}   <= req_mode[2*int'(w_winner) +: 2];
                        r_busy                   <= 1'b1;
                        r_state                  <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_eng_start <= 1'b1;
                    r_tcnt      <= '0;
                    r_state     <= c_RUN;
                end
                c_RUN: begin
                    r_eng_start <= 1'b0;
                    if (eng_done) begin
                        r_ack   <= r_grant;
                        r_err   <= '0;
                        r_rr    <= r_owner;
                        r_gcnt  <= '0;
                        r_state <= c_GAP;
                    end else if (r_tcnt == c_TCNT_LAST) begin
                        r_ack   <= r_grant;
                        r_err   <= r_grant;
                        r_rr    <= r_owner;
                        r_gcnt  <= '0;
                        r_state <= c_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + c_TCNT_W'(1);
                    end
                end
                c_GAP: begin
                    r_ack   <= '0;
                    r_err   <= '0;
                    r_grant <= '0;
                    r_gcnt  <= r_gcnt + c_GCNT_W'(1);
                    if (r_gcnt == c_GCNT_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign grant        = r_grant;
    assign ack          = r_ack;
    assign err          = r_err;
    assign busy         = r_busy;
    assign state        = r_state;
    assign eng_data_wr  = r_eng_data;
    assign eng_polarity = r_eng_pol;
    assign eng_phase    = r_eng_pha;
    assign eng_start    = r_eng_start;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_bus_arbiter
// Description : Self-checking bench for spi_bus_arbiter: directed and random
//               frames checked against a transaction-level round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int GAP = 4;
    localparam int TO  = 24;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR*2-1:0] req_mode;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   err;
    logic            busy;
    logic [1:0]      state;
    logic [DW-1:0]   eng_data_wr;
    logic            eng_polarity;
    logic            eng_phase;
    logic            eng_start;
    logic            eng_busy;
    logic            eng_done;

    spi_bus_arbiter #(
        .NUM_REQ    (NR),
        .DATA_W     (DW),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .req_mode     (req_mode),
        .grant        (grant),
        .ack          (ack),
        .err          (err),
        .busy         (busy),
        .state        (state),
        .eng_data_wr  (eng_data_wr),
        .eng_polarity (eng_polarity),
        .eng_phase    (eng_phase),
        .eng_start    (eng_start),
        .eng_busy     (eng_busy),
        .eng_done     (eng_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: requester levels, their payloads, and the last owner.
    logic [NR-1:0] mask;
    logic [DW-1:0] dat [NR];
    logic [1:0]    mode [NR];
    int            last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] m, input int l);
        for (int off = 1; off <= NR; off++) begin
            if (m[(l + off) % NR]) return (l + off) % NR;
        end
        return -1;
    endfunction

    task automatic apply();
        req = mask;
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = dat[i];
            req_mode[2*i +: 2]   = mode[i];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'(0));
        chk({tag, "_ack"},   64'(ack),   64'(0));
        chk({tag, "_err"},   64'(err),   64'(0));
        chk({tag, "_busy"},  64'(busy),  64'(0));
        chk({tag, "_state"}, 64'(state), 64'(0));
        chk({tag, "_data"},  64'(eng_data_wr), 64'(0));
        chk({tag, "_mode"},  64'({eng_polarity, eng_phase}), 64'(0));
        chk({tag, "_start"}, 64'(eng_start), 64'(0));
    endtask

    // One frame from an idle arbiter; k is the RUN cycle in which the engine
    // pulses done (-1: never). Returns at the negedge of the first IDLE cycle.
    task automatic frame(input int k);
        int            w;
        int            exitc;
        bit            tmo;
        logic [DW-1:0] ed;
        logic [1:0]    em;
        w     = rr_pick(mask, last);
        ed    = dat[w];
        em    = mode[w];
        tmo   = (k < 0) || (k > TO - 1);
        exitc = tmo ? TO - 1 : k;
        @(negedge clk);
        chk("grant_onehot", 64'(grant), 64'(1 << w));
        chk("state_load",   64'(state), 64'(1));
        chk("busy_load",    64'(busy),  64'(1));
        chk("data_latch",   64'(eng_data_wr), 64'(ed));
        chk("mode_latch",   64'({eng_polarity, eng_phase}), 64'(em));
        chk("start_in_load", 64'(eng_start), 64'(0));
        dat[w]  = 8'($urandom);
        mode[w] = 2'($urandom);
        apply();
        @(negedge clk);
        chk("state_run", 64'(state), 64'(2));
        chk("start_pulse", 64'(eng_start), 64'(1));
        for (int c = 0; c <= exitc; c++) begin
            eng_done = (c == k);
            @(negedge clk);
            eng_done = 1'b0;
            if (c < exitc) begin
                chk("run_hold",  64'(state), 64'(2));
                chk("run_noack", 64'(ack), 64'(0));
                chk("start_single", 64'(eng_start), 64'(0));
            end
        end
        chk("ack",       64'(ack),   64'(1 << w));
        chk("err",       64'(err),   tmo ? 64'(1 << w) : 64'(0));
        chk("state_gap", 64'(state), 64'(3));
        chk("grant_ack", 64'(grant), 64'(1 << w));
        chk("data_hold", 64'(eng_data_wr), 64'(ed));
        chk("mode_hold", 64'({eng_polarity, eng_phase}), 64'(em));
        mask[w] = 1'b0;
        last    = w;
        apply();
        for (int g = 1; g < GAP; g++) begin
            @(negedge clk);
            chk("gap_state", 64'(state), 64'(3));
            chk("gap_ack",   64'(ack),   64'(0));
            chk("gap_grant", 64'(grant), 64'(0));
            chk("gap_busy",  64'(busy),  64'(1));
        end
        @(negedge clk);
        chk("idle_state", 64'(state), 64'(0));
        chk("idle_busy",  64'(busy),  64'(0));
        chk("idle_ack",   64'(ack),   64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        eng_busy = 1'b0;
        eng_done = 1'b0;
        mask     = '0;
        for (int i = 0; i < NR; i++) begin
            dat[i]  = 8'($urandom);
            mode[i] = 2'($urandom);
        end
        apply();
        last = NR - 1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Single request with a known byte and mode, done after 20 cycles.
        dat[2]  = 8'hA5;
        mode[2] = 2'b10;
        mask    = 4'b0100;
        apply();
        frame(20);

        // Fresh reset, then all four requesters held: expect 0,1,2,3.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last  = NR - 1;
        mask  = 4'b1111;
        apply();
        for (int i = 0; i < NR; i++) begin
            chk("rr_order", 64'(rr_pick(mask, last)), 64'(i));
            frame(int'($urandom_range(0, 10)));
        end

        // Engine never answers requester 1: timeout.
        mask = 4'b0010;
        apply();
        frame(-1);

        // Async reset 5 cycles into RUN abandons the frame.
        dat[1] = 8'h3C;
        mask   = 4'b0010;
        apply();
        repeat (7) @(negedge clk);
        chk("pre_reset_run", 64'(state), 64'(2));
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        mask = '0;
        apply();
        @(negedge clk);
        reset = 1'b0;
        last  = NR - 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_noack", 64'(ack), 64'(0));
            chk("post_reset_idle",  64'(state), 64'(0));
        end
        mask = 4'b0111;
        apply();
        while (mask != 0) frame(int'($urandom_range(0, 6)));

        // Done and timeout on the same edge, then done one cycle earlier.
        mask = 4'b0001;
        apply();
        frame(TO - 1);
        mask = 4'b0001;
        apply();
        frame(TO - 2);

        // Done pulse while idle must be ignored.
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("idle_done_state", 64'(state), 64'(0));
        chk("idle_done_ack",   64'(ack),   64'(0));
        @(negedge clk);
        chk("idle_done_busy",  64'(busy),  64'(0));

        // Engine busy holds off the grant.
        eng_busy = 1'b1;
        mask     = 4'b1000;
        apply();
        repeat (10) begin
            @(negedge clk);
            chk("busy_nogrant", 64'(grant), 64'(0));
            chk("busy_idle",    64'(state), 64'(0));
        end
        eng_busy = 1'b0;
        frame(5);

        // Random batches of simultaneous requests.
        repeat (10) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                dat[i]  = 8'($urandom);
                mode[i] = 2'($urandom);
            end
            apply();
            while (mask != 0) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0)      frame(-1);
                else if (r == 1) frame(TO - 1);
                else             frame(int'($urandom_range(0, 12)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
